clint: RTL
==========

# clint

Core-local interruptor feeding the machine-mode CSR block's timer and software interrupt-pending inputs. Holds the 64-bit `mtime` counter, the 64-bit `mtimecmp` compare register and the `msip` bit, all behind a single-outstanding valid/ready memory-mapped slave port. Drives `tmr_ip` and `sft_ip`, which the CSR block samples into `mip.MTIP` and `mip.MSIP`.

## Interface
- `TICK_DIV`, default 1: `mtime` increments once every `TICK_DIV` clk cycles; legal range 1..65535.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `cmd_valid`  in  1  request valid.
- `cmd_ready`  out  1  request accepted when `cmd_valid & cmd_ready`.
- `cmd_read`  in  1  1 = read, 0 = write.
- `cmd_addr`  in  16  byte offset within the CLINT region.
- `cmd_wdata`  in  32  write data; full-word writes only.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata`  out  32  read data; 0 for writes and for errors.
- `rsp_err`  out  1  unmapped or misaligned access.
- `tmr_ip`  out  1  timer interrupt pending.
- `sft_ip`  out  1  software interrupt pending.

## Operation
- Register map, word-aligned:
  - 0x0000: `msip`. Bit 0 is R/W; bits 31:1 read 0.
  - 0x4000 / 0x4004: `mtimecmp` low / high.
  - 0xBFF8 / 0xBFFC: `mtime` low / high.
- Any other address, or `cmd_addr[1:0] != 0`:
  - `rsp_err=1`, `rsp_rdata=0`.
  - Writes have no side effect.
- Two-state handshake FSM:
  - IDLE: `cmd_ready=1`. On accept, go to RSP.
  - RSP: `cmd_ready=0`, `rsp_valid=1`. Hold until `rsp_ready`, then return to IDLE.
  - No back-to-back accept in the cycle `rsp_ready` completes; one request per two cycles minimum.
- Write side effects commit on the clock edge of accept.
- Read data is captured at accept and held stable throughout RSP.
- Prescaler: a 16-bit counter counts 0..`TICK_DIV-1`. `tick` is asserted when the counter equals `TICK_DIV-1`, and the counter then wraps to 0. With `TICK_DIV=1`, `tick` is asserted every cycle.
- `mtime` on `tick` is a 64-bit increment: low word 0xFFFFFFFF wraps to 0 and carries into high; 0xFFFFFFFF_FFFFFFFF wraps to 0.
- Write to either `mtime` half in the same cycle as `tick`:
  - The write wins for the addressed half.
  - The other half holds its value; no increment or carry that cycle.
- `tmr_ip` is registered: `tmr_ip <= (mtime >= mtimecmp)`, unsigned 64-bit compare of the current register values.
- `sft_ip` equals the `msip` register bit directly.

## Timing
- Reset values:
  - `mtime=0`, `mtimecmp=0xFFFFFFFF_FFFFFFFF`, `msip=0`, prescaler 0.
  - FSM in IDLE: `cmd_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
  - `tmr_ip=0`, `sft_ip=0`.
- Command accept at edge N: response valid from cycle N+1.
- `msip` write accepted at edge N: `sft_ip` changes after edge N.
- `mtimecmp` or `mtime` write accepted at edge N: registers update at edge N; `tmr_ip` reflects the new compare after edge N+1.
- `tmr_ip` lags `mtime` crossing `mtimecmp` by one cycle.
- Reset asserted mid-transaction: any pending response is dropped and all state returns to reset values asynchronously. No response is issued after reset release.
- 64-bit reads are not atomic. Software reads high/low/high; the block gives no snapshot.

## Structure
- Shared package:
  - Address constants `CLINT_MSIP`, `CLINT_MTIMECMP_LO/HI`, `CLINT_MTIME_LO/HI`.
  - FSM state encoding (IDLE=0, RSP=1).
  - Reset constant `MTIMECMP_RST`.
- One sub-module, `clint_mtime`: prescaler, 64-bit counter, per-half write port with write-over-tick priority, and the registered compare producing `tmr_ip`.
- Top level holds the handshake FSM, address decode, `msip` and `mtimecmp`. Use the codebase `dffr`/`dfflr` flops throughout.

## Test plan
- Reset, then read 0x4000 and 0x4004 -> both return 0xFFFFFFFF, `rsp_err=0`; `tmr_ip=0`, `sft_ip=0`.
- `TICK_DIV=4`: after reset, wait 40 cycles, read 0xBFF8 -> value in 9..10; the value advances by exactly 1 every 4 cycles.
- Write `mtime` low=0xFFFFFFFE, high=0, `TICK_DIV=1` -> within 3 cycles reading 0xBFFC returns 1 and 0xBFF8 returns 0 or 1 (carry check).
- Write `mtimecmp` high=0, low=20, with `mtime` near 0 -> `tmr_ip` rises exactly one cycle after `mtime` reaches 20. Then write `mtimecmp` high=1 -> `tmr_ip` falls 2 cycles after accept.
- Write 1 to 0x0000 -> `sft_ip=1` the cycle after accept; read 0x0000 returns 0x1. Write 0 -> `sft_ip=0`.
- Read 0x0010 and 0x4002 -> `rsp_err=1`, `rsp_rdata=0`, no state change. Hold `rsp_ready=0` for 5 cycles -> `rsp_valid` and data stay stable and `cmd_ready=0` throughout. Assert `rst_n` low during RSP -> `rsp_valid=0` immediately.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared constants, FSM encoding and address decode for the core-local interruptor.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } clint_state_e;

  typedef struct packed {
    logic msip;
    logic cmp_lo;
    logic cmp_hi;
    logic mtime_lo;
    logic mtime_hi;
  } clint_sel_t;

  // Map constants are word aligned, so a misaligned offset never matches and
  // falls out as "no register selected", i.e. an error.
  function automatic clint_sel_t clint_decode(input logic [15:0] addr);
    clint_sel_t sel;
    sel = '0;
    case (addr)
      CLINT_MSIP:        sel.msip     = 1'b1;
      CLINT_MTIMECMP_LO: sel.cmp_lo   = 1'b1;
      CLINT_MTIMECMP_HI: sel.cmp_hi   = 1'b1;
      CLINT_MTIME_LO:    sel.mtime_lo = 1'b1;
      CLINT_MTIME_HI:    sel.mtime_hi = 1'b1;
      default:           sel          = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/clint_if.sv
// Single-outstanding valid/ready command/response port of the CLINT.
interface clint_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/clint_mtime.sv
// Prescaled 64-bit mtime counter with per-half write port and registered
// timer compare.
module clint_mtime #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] mtimecmp_i,
  output logic [63:0] mtime_o,
  output logic        tmr_ip_o
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic        tmr_ip_q, tmr_ip_d;
  logic        tick;

  assign tick = (presc_q == TICK_LAST);

  // Prescaler wraps to 0 on the cycle it produces a tick.
  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
  end

  // A software write suppresses that cycle's increment entirely, so the
  // unwritten half neither counts nor receives a carry.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) mtime_d[31:0]  = wdata_i;
      if (wr_hi_i) mtime_d[63:32] = wdata_i;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  // Compare uses current register values; the pending bit lags by one cycle.
  always_comb begin
    tmr_ip_d = (mtime_q >= mtimecmp_i);
  end

  dffr #(.W(16)) u_presc (.clk_i, .rst_ni, .d_i(presc_d),  .q_o(presc_q));
  dffr #(.W(64)) u_mtime (.clk_i, .rst_ni, .d_i(mtime_d),  .q_o(mtime_q));
  dffr #(.W(1))  u_tmr   (.clk_i, .rst_ni, .d_i(tmr_ip_d), .q_o(tmr_ip_q));

  assign mtime_o  = mtime_q;
  assign tmr_ip_o = tmr_ip_q;

endmodule

// File: rtl/dfflr.sv
// Resettable flop with load enable.
module dfflr #(
  parameter int unsigned W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Load d_i only when enabled, otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   q_o <= RST;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/dffr.sv
// Resettable flop with configurable width and reset value.
module dffr #(
  parameter int unsigned W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Plain register with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_o <= RST;
    else         q_o <= d_i;
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: handshake FSM, register decode, msip and mtimecmp.
//
// state | meaning
// IDLE  | ready for a command; accept moves to RSP
// RSP   | response held valid until rsp_ready, then back to IDLE
module clint
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  clint_if.slave bus,
  output logic   tmr_ip_o,
  output logic   sft_ip_o
);

  logic [0:0]   state_raw;
  clint_state_e state_q, state_d;
  clint_sel_t   sel;
  logic         accept, wr, err_d, err_q;
  logic [31:0]  rdata_mux, rdata_d, rdata_q;
  logic         msip_q;
  logic [31:0]  cmp_lo_q, cmp_hi_q;
  logic [63:0]  mtime;

  dffr #(.W(1), .RST(1'b0)) u_state (.clk_i, .rst_ni, .d_i(state_d), .q_o(state_raw));
  assign state_q = clint_state_e'(state_raw);

  // Next state: one request per two cycles, no accept while a response is pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.cmd_valid) state_d = ST_RSP;
      ST_RSP:  if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state.
  always_comb begin
    bus.cmd_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RSP);
  end

  assign accept = bus.cmd_valid && (state_q == ST_IDLE);
  assign sel    = clint_decode(bus.cmd_addr);
  assign err_d  = ~|sel;
  assign wr     = accept && !bus.cmd_read;

  // Read mux; unselected (error) accesses return zero.
  always_comb begin
    rdata_mux = '0;
    if (sel.msip)     rdata_mux = {31'd0, msip_q};
    if (sel.cmp_lo)   rdata_mux = cmp_lo_q;
    if (sel.cmp_hi)   rdata_mux = cmp_hi_q;
    if (sel.mtime_lo) rdata_mux = mtime[31:0];
    if (sel.mtime_hi) rdata_mux = mtime[63:32];
  end

  assign rdata_d = bus.cmd_read ? rdata_mux : 32'd0;

  // Response is captured at accept so it stays stable however long RSP lasts.
  dfflr #(.W(32)) u_rdata (.clk_i, .rst_ni, .en_i(accept), .d_i(rdata_d), .q_o(rdata_q));
  dfflr #(.W(1))  u_err   (.clk_i, .rst_ni, .en_i(accept), .d_i(err_d),   .q_o(err_q));

  dfflr #(.W(1)) u_msip (
    .clk_i, .rst_ni, .en_i(wr && sel.msip), .d_i(bus.cmd_wdata[0]), .q_o(msip_q)
  );
  dfflr #(.W(32), .RST(MTIMECMP_RST[31:0])) u_cmp_lo (
    .clk_i, .rst_ni, .en_i(wr && sel.cmp_lo), .d_i(bus.cmd_wdata), .q_o(cmp_lo_q)
  );
  dfflr #(.W(32), .RST(MTIMECMP_RST[63:32])) u_cmp_hi (
    .clk_i, .rst_ni, .en_i(wr && sel.cmp_hi), .d_i(bus.cmd_wdata), .q_o(cmp_hi_q)
  );

  clint_mtime #(.TICK_DIV(TICK_DIV)) u_mtime (
    .clk_i,
    .rst_ni,
    .wr_lo_i   (wr && sel.mtime_lo),
    .wr_hi_i   (wr && sel.mtime_hi),
    .wdata_i   (bus.cmd_wdata),
    .mtimecmp_i({cmp_hi_q, cmp_lo_q}),
    .mtime_o   (mtime),
    .tmr_ip_o  (tmr_ip_o)
  );

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign sft_ip_o      = msip_q;

endmodule
